// File: rtl/multicycle_controller.sv
// Moore-style control FSM for the multicycle RV32I core with a memory-wait watchdog and sticky fault.
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    input  logic        LessThanS,
    input  logic        LessThanU,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUControl,
    output logic [2:0]  LoadType,
    output logic        fault,
    output logic [3:0]  state_o,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXECR  = 4'd6,  S_EXECI = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR  = 4'd11,
        S_LUI    = 4'd12, S_AUIPC  = 4'd13, S_FAULT  = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;

    localparam bit             LP_WD_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LP_TO  = CNT_W'(MEM_TIMEOUT);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_wait;
    logic             r_fault;
    logic             w_mem_st, w_enter_mem, w_timeout, w_take, w_br_ill;
    logic             w_pcw, w_irw, w_rw, w_mr, w_mw;
    logic [3:0]       w_alu_dec;

    assign w_mem_st  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout = LP_WD_EN && (r_wait == LP_TO) && !mem_ready;
    assign w_enter_mem = (w_next != r_state) &&
                         ((w_next == S_FETCH) || (w_next == S_MEMRD) || (w_next == S_MEMWR));
    assign w_br_ill  = (funct3 == 3'b010) || (funct3 == 3'b011);

    always_comb begin
        w_take = 1'b0;
        case (funct3)
            3'b000:  w_take = Zero;
            3'b001:  w_take = !Zero;
            3'b100:  w_take = LessThanS;
            3'b101:  w_take = !LessThanS;
            3'b110:  w_take = LessThanU;
            3'b111:  w_take = !LessThanU;
            default: w_take = 1'b0;
        endcase
    end

    // SUB only exists for register-register ops; I-type funct7b5 is part of the immediate.
    always_comb begin
        w_alu_dec = ALU_ADD;
        case (funct3)
            3'b000: w_alu_dec = (r_state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: w_alu_dec = ALU_SLL;
            3'b010: w_alu_dec = ALU_SLT;
            3'b011: w_alu_dec = ALU_SLTU;
            3'b100: w_alu_dec = ALU_XOR;
            3'b101: w_alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: w_alu_dec = ALU_OR;
            3'b111: w_alu_dec = ALU_AND;
            default: w_alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_pcw      = 1'b0;
        w_irw      = 1'b0;
        w_rw       = 1'b0;
        w_mr       = 1'b0;
        w_mw       = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        LoadType   = 3'b000;
        case (r_state)
            S_FETCH: begin
                w_mr      = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    w_irw  = 1'b1;
                    w_pcw  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECR;
                    7'b0010011:             w_next = S_EXECI;
                    7'b1100011:             w_next = S_BRANCH;
                    7'b1101111:             w_next = S_JAL;
                    7'b1100111:             w_next = S_JALR;
                    7'b0110111:             w_next = S_LUI;
                    7'b0010111:             w_next = S_AUIPC;
                    default:                w_next = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == 7'b0100011) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mr     = 1'b1;
                AdrSrc   = 1'b1;
                LoadType = funct3;
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_rw      = 1'b1;
                LoadType  = funct3;
                w_next    = S_FETCH;
            end
            S_MEMWR: begin
                w_mw   = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = w_alu_dec;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                w_rw   = 1'b1;
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                w_pcw      = w_take && !w_br_ill;
                w_next     = w_br_ill ? S_FAULT : S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                w_pcw   = 1'b1;
                w_next  = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcw     = 1'b1;
                w_rw      = 1'b1;
                w_next    = S_FETCH;
            end
            S_LUI: begin
                ResultSrc = 2'b01;
                w_rw      = 1'b1;
                w_next    = S_FETCH;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                w_next  = S_ALUWB;
            end
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_fault <= r_fault | (w_next == S_FAULT);
            if (w_enter_mem)
                r_wait <= '0;
            else if (w_mem_st && !mem_ready)
                r_wait <= r_wait + CNT_W'(1);
        end
    end

    // Strobes are masked by reset so nothing fires while the async reset is held.
    assign PCWrite  = w_pcw & ~reset;
    assign IRWrite  = w_irw & ~reset;
    assign RegWrite = w_rw  & ~reset;
    assign MemRead  = w_mr  & ~reset;
    assign MemWrite = w_mw  & ~reset;
    assign fault    = r_fault;
    assign state_o  = r_state;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] r_instret;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_instret <= '0;
        else if (w_next == S_FETCH && r_state != S_FETCH)
            r_instret <= r_instret + 32'd1;
    end
    assign instret = r_instret;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and random instruction streams checked against an instruction-level plan of expected states.
module tb_multicycle_controller;
    localparam int TO = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0, Zero = 1'b0, LessThanS = 1'b0, LessThanU = 1'b0, mem_ready = 1'b0;
    logic        PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, fault;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0]  ALUControl, state_o;
    logic [2:0]  LoadType;
    logic [31:0] instret;

    int checks = 0, errors = 0, exp_instret = 0;
    int q_st[$];
    bit q_rdy[$];
    bit plan_fault;
    logic [6:0] c_op;
    logic [2:0] c_f3;
    logic c_f7, c_z, c_lts, c_ltu;

    multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .LessThanS(LessThanS), .LessThanU(LessThanU), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .LoadType(LoadType), .fault(fault),
        .state_o(state_o), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (op %b f3 %b)", tag, obs, exp, c_op, c_f3);
        end
    endtask

    function automatic logic [31:0] instret_exp();
`ifdef CTRL_PERF_CNT_EN
        return 32'(exp_instret);
`else
        return 32'd0;
`endif
    endfunction

    function automatic bit take();
        case (c_f3)
            3'd0: return c_z;
            3'd1: return !c_z;
            3'd4: return c_lts;
            3'd5: return !c_lts;
            3'd6: return c_ltu;
            3'd7: return !c_ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int e_alu(int s);
        if (s == 6 || s == 7) begin
            case (c_f3)
                3'd0: return (s == 6 && c_f7) ? 1 : 0;
                3'd1: return 2;
                3'd2: return 3;
                3'd3: return 4;
                3'd4: return 5;
                3'd5: return c_f7 ? 7 : 6;
                3'd6: return 8;
                default: return 9;
            endcase
        end
        if (s == 9) return 1;
        if (s == 0 || s == 1 || s == 2 || s == 10 || s == 11 || s == 13) return 0;
        return -1;
    endfunction

    function automatic int e_rs(int s);
        case (s)
            0, 11: return 2;
            4, 12: return 1;
            8, 9, 10: return 0;
            default: return -1;
        endcase
    endfunction

    function automatic int e_sa(int s);
        case (s)
            0: return 0;
            1, 10, 13: return 1;
            2, 6, 7, 9, 11: return 2;
            default: return -1;
        endcase
    endfunction

    function automatic int e_sb(int s);
        case (s)
            0, 10: return 2;
            1, 2, 7, 11, 13: return 1;
            6, 9: return 0;
            default: return -1;
        endcase
    endfunction

    task automatic push(input int st, input bit rdy);
        q_st.push_back(st);
        q_rdy.push_back(rdy);
    endtask

    // A memory access that waits w cycles either completes (w <= TO) or trips the watchdog.
    task automatic push_mem(input int st, input int w, output bit ok);
        if (w <= TO) begin
            for (int i = 0; i < w; i++) push(st, 1'b0);
            push(st, 1'b1);
            ok = 1'b1;
        end else begin
            for (int i = 0; i <= TO; i++) push(st, 1'b0);
            ok = 1'b0;
        end
    endtask

    task automatic push_fault();
        for (int i = 0; i < 4; i++) push(15, 1'($urandom_range(0, 1)));
        plan_fault = 1'b1;
    endtask

    task automatic build(input int wf, input int wm);
        bit ok;
        q_st.delete();
        q_rdy.delete();
        plan_fault = 1'b0;
        push_mem(0, wf, ok);
        if (!ok) begin push_fault(); return; end
        push(1, 1'($urandom_range(0, 1)));
        case (c_op)
            7'b0000011: begin
                push(2, 1'($urandom_range(0, 1)));
                push_mem(3, wm, ok);
                if (ok) push(4, 1'($urandom_range(0, 1))); else push_fault();
            end
            7'b0100011: begin
                push(2, 1'($urandom_range(0, 1)));
                push_mem(5, wm, ok);
                if (!ok) push_fault();
            end
            7'b0110011: begin push(6, 1'b1); push(8, 1'b0); end
            7'b0010011: begin push(7, 1'b0); push(8, 1'b1); end
            7'b1100011: begin
                push(9, 1'($urandom_range(0, 1)));
                if (c_f3 == 3'd2 || c_f3 == 3'd3) push_fault();
            end
            7'b1101111: begin push(10, 1'b0); push(8, 1'b1); end
            7'b1100111: push(11, 1'b0);
            7'b0110111: push(12, 1'b1);
            7'b0010111: begin push(13, 1'b0); push(8, 1'b0); end
            default: push_fault();
        endcase
    endtask

    task automatic run(input int stop_after);
        int s, e;
        bit r;
        for (int k = 0; k < q_st.size(); k++) begin
            if (stop_after > 0 && k >= stop_after) return;
            s = q_st[k];
            r = q_rdy[k];
            op = c_op; funct3 = c_f3; funct7b5 = c_f7;
            Zero = c_z; LessThanS = c_lts; LessThanU = c_ltu; mem_ready = r;
            @(negedge clk);
            chk("state", 32'(state_o), 32'(s));
            chk("PCWrite", 32'(PCWrite), (s == 0) ? 32'(r) : (s == 9) ? 32'(take()) : 32'(s == 10 || s == 11));
            chk("IRWrite", 32'(IRWrite), 32'(s == 0 && r));
            chk("RegWrite", 32'(RegWrite), 32'(s == 4 || s == 8 || s == 11 || s == 12));
            chk("MemRead", 32'(MemRead), 32'(s == 0 || s == 3));
            chk("MemWrite", 32'(MemWrite), 32'(s == 5));
            chk("LoadType", 32'(LoadType), (s == 3 || s == 4) ? 32'(c_f3) : 32'd0);
            chk("fault", 32'(fault), 32'(s == 15));
            chk("instret", instret, instret_exp());
            e = e_alu(s);
            if (e >= 0) chk("ALUControl", 32'(ALUControl), 32'(e));
            e = e_rs(s);
            if (e >= 0) chk("ResultSrc", 32'(ResultSrc), 32'(e));
            e = e_sa(s);
            if (e >= 0) chk("ALUSrcA", 32'(ALUSrcA), 32'(e));
            e = e_sb(s);
            if (e >= 0) chk("ALUSrcB", 32'(ALUSrcB), 32'(e));
            if (s == 0 || s == 3 || s == 5) chk("AdrSrc", 32'(AdrSrc), 32'(s != 0));
            @(posedge clk);
            #1;
        end
        if (!plan_fault) exp_instret++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_strobes", {27'd0, PCWrite, MemRead, MemWrite, IRWrite, RegWrite}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_instret = 0;
        #1;
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_instret", instret, 32'd0);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input logic lts, input logic ltu);
        c_op = o; c_f3 = f3; c_f7 = f7; c_z = z; c_lts = lts; c_ltu = ltu;
    endtask

    logic [6:0] legal_ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                   7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0110011};
    logic [6:0] bad_ops [3] = '{7'b0001111, 7'b1110011, 7'b0000000};

    initial begin
        set_instr(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("init_state", 32'(state_o), 32'd0);
        chk("init_strobes", {27'd0, PCWrite, MemRead, MemWrite, IRWrite, RegWrite}, 32'd0);
        chk("init_fault", 32'(fault), 32'd0);
        chk("init_instret", instret, 32'd0);
        reset = 1'b0;
        #1;

        // add x3,x1,x2
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        build(0, 0); run(0);
        // bne taken, then not taken
        set_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        build(0, 0); run(0);
        set_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
        build(0, 0); run(0);
        // lw with three wait cycles in MEMRD
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        build(0, 3); run(0);
        // reset while the load is still waiting for memory
        build(0, 9); run(6);
        apply_reset();
        // fetch never answered
        set_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        build(9, 0); run(0);
        apply_reset();
        // illegal opcode, then branch with reserved funct3
        set_instr(7'b0001111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        build(0, 0); run(0);
        apply_reset();
        set_instr(7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1);
        build(0, 0); run(0);
        apply_reset();

        for (int n = 0; n < 300; n++) begin
            int wf, wm;
            logic [6:0] o;
            o = ($urandom_range(0, 19) == 0) ? bad_ops[$urandom_range(0, 2)] : legal_ops[$urandom_range(0, 9)];
            set_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wf = ($urandom_range(0, 29) == 0) ? 5 + $urandom_range(0, 2) : $urandom_range(0, TO);
            wm = ($urandom_range(0, 29) == 0) ? 5 + $urandom_range(0, 2) : $urandom_range(0, TO);
            build(wf, wm);
            run(0);
            if (plan_fault) apply_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequential control unit for the multicycle RV32I core; it replaces the single-cycle controller.
- A Moore FSM sequences fetch, decode, execute, memory and writeback over a shared memory port that uses a ready handshake.
- It generates the datapath strobes, branch decisions, ALU operation and load type.
- It also adds a memory-timeout watchdog and sticky fault reporting for illegal instructions.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready per access; 0 disables the watchdog.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- Zero, LessThanS, LessThanU  in  1 each  ALU flags.
- mem_ready  in  1  memory access completes this cycle.
- PCWrite  out  1  PC load enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  read request.
- MemWrite  out  1  write request.
- IRWrite  out  1  IR and OldPC load.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A register.
- ALUSrcB  out  2  00 = B register, 01 = ImmExt, 10 = constant 4.
- ALUControl  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- LoadType  out  3  funct3 during MEMRD/MEMWB, else 0.
- fault  out  1  sticky error flag.
- state_o  out  4  current state encoding.
- instret  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset:
  - Asynchronous and active-high.
  - state = FETCH, wait counter = 0, fault = 0, instret = 0.
  - While reset is high, every strobe is forced to 0: PCWrite, MemRead, MemWrite, IRWrite, RegWrite.
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXECR, 7 EXECI, 8 ALUWB, 9 BRANCH, 10 JAL, 11 JALR, 12 LUI, 13 AUIPC, 15 FAULT.
- FETCH:
  - Outputs: MemRead = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUControl = ADD, ResultSrc = 10.
  - On mem_ready: IRWrite = 1, PCWrite = 1, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Outputs: ALUSrcA = 01, ALUSrcB = 01, ADD (branch/JAL target into ALUOut).
  - Next state by op:
    - 0000011 and 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - any other opcode → FAULT
- MEMADR:
  - Outputs: A + Imm, ADD.
  - Next: MEMRD for loads, MEMWR for stores.
- MEMRD:
  - Outputs: MemRead = 1, AdrSrc = 1.
  - Wait for mem_ready, then go to MEMWB.
- MEMWB:
  - Outputs: ResultSrc = 01, RegWrite = 1.
  - Next: FETCH.
- MEMWR:
  - Outputs: MemWrite = 1, AdrSrc = 1, held until mem_ready.
  - Next: FETCH.
- EXECR / EXECI:
  - Sources: A op B for EXECR; A op Imm for EXECI.
  - ALU decode by funct3: 000 ADD, with SUB only when EXECR and funct7b5 = 1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7b5 = 1; 110 OR; 111 AND.
  - Next: ALUWB.
- ALUWB:
  - Outputs: ResultSrc = 00, RegWrite = 1.
  - Next: FETCH.
- BRANCH:
  - Outputs: A − B (SUB), ResultSrc = 00.
  - PCWrite = take, where take depends on funct3:
    - 000 Zero
    - 001 !Zero
    - 100 LessThanS
    - 101 !LessThanS
    - 110 LessThanU
    - 111 !LessThanU
  - funct3 010 or 011 → FAULT with no PC write.
  - Otherwise next: FETCH.
- JAL:
  - Outputs: ALUSrcA = 01, ALUSrcB = 10, ADD, ResultSrc = 00 (target from DECODE), PCWrite = 1.
  - Next: ALUWB. ALUWB then writes OldPC + 4, held in ALUOut.
- JALR:
  - Outputs: A + Imm, ResultSrc = 10, PCWrite = 1, RegWrite = 1.
  - The link value comes from the datapath's OldPC + 4 path.
  - Next: FETCH.
- LUI:
  - Outputs: ResultSrc = 01 via the immediate bypass, RegWrite = 1.
  - Next: FETCH.
- AUIPC:
  - Outputs: OldPC + Imm, ADD.
  - Next: ALUWB.
- Wait counter:
  - Clears on entry to any memory state.
  - Increments each cycle the state is FETCH, MEMRD or MEMWR and mem_ready = 0.
  - When MEM_TIMEOUT ≠ 0 and counter == MEM_TIMEOUT with mem_ready still 0 → FAULT.
  - mem_ready in the same cycle as the timeout wins: the access completes.
- FAULT:
  - All strobes are 0 and fault = 1.
  - FAULT is terminal; only reset leaves it.
- Timing:
  - Outputs are combinational from state. mem_ready and the flags gate only PCWrite and IRWrite and the transitions.
  - Instruction latency with zero-wait memory, in cycles: load 5, store 4, R/I 4, branch 3, JAL 4, JALR 3, LUI 3, AUIPC 4.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined: instret increments by 1 on every transition into FETCH from any non-FETCH state, wraps modulo 2^32, and is cleared by reset.
- Undefined: instret is tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset mid-MEMRD (reset asserted while waiting) → state_o = 0 and all strobes 0 immediately; fault = 0 after release.
- add x3, x1, x2 (op 0110011, funct3 000, funct7b5 0) with mem_ready = 1 → state sequence 0, 1, 6, 8, 0; ALUControl 0 in EXECR; RegWrite = 1 only in ALUWB.
- bne with Zero = 0, then bne with Zero = 1 → PCWrite = 1 in BRANCH for the first, 0 for the second; both return to FETCH after 3 cycles.
- Load lw with mem_ready low for 3 cycles in MEMRD → MemRead held high for 4 cycles; LoadType = 010; MEMWB reached; instret +1 when the macro is defined.
- MEM_TIMEOUT = 4 and mem_ready stuck at 0 in FETCH → FAULT after 5 FETCH cycles; fault = 1 sticky; no IRWrite.
- Illegal op 0001111, and branch with funct3 = 010 → FAULT entered from DECODE and BRANCH respectively, with PCWrite = 0.
